seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Parametrised time-multiplexed 7-segment driver for the board display.
//   Scans DIGITS common-anode digits (one active per scan slot) and decodes
//   hex nibbles. Adds per-digit blank, decimal point, blink and leading-zero
//   suppression. Shadow-latched data is applied only at frame boundaries.
//   Sits between game/score logic and the AN/SEGMENT board pins.
// PARAMETERS
//   DIGITS        4      number of digits scanned (>=2)
//   SCAN_DIV      50000  clk cycles per digit slot (>=2)
//   BLINK_FRAMES  64     full frames per blink half-period (>=1)
//   LZ_SUPPRESS   0      1 = blank leading zero digits (digit 0 never blanked)
// PORTS
//   clk       in   1           system clock, all logic on rising edge
//   rst       in   1           synchronous reset, active-high
//   load      in   1           capture disp_num/dp_en/blank/blink_en into shadow
//   disp_num  in   4*DIGITS    hex nibbles; [3:0] = digit 0 (rightmost)
//   dp_en     in   DIGITS      1 = light decimal point of digit i
//   blank     in   DIGITS      1 = digit i dark (overrides everything)
//   blink_en  in   DIGITS      1 = digit i dark during blink-off phase
//   AN        out  DIGITS      digit enables, active-low, one-cold
//   SEGMENT   out  8           {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//   Reset: AN all 1, SEGMENT 8'hFF, div_cnt=0, idx=0, frame_cnt=0,
//     blink_off=0, load_pend=0, shadow and active registers all 0.
//   div_cnt counts 0..SCAN_DIV-1, wraps; tick = (div_cnt==SCAN_DIV-1).
//   On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1. Wrap of idx = frame end.
//   load=1: shadow <= inputs, load_pend <= 1 (same edge). A later load
//     before frame end overwrites the shadow; only the last one is applied.
//   At frame end: if load_pend, active <= shadow, load_pend <= 0. If load
//     and frame end coincide, the new inputs go straight to active and
//     load_pend stays 0.
//   Blink: frame_cnt counts frames 0..BLINK_FRAMES-1; on its wrap
//     blink_off toggles.
//   LZ: with LZ_SUPPRESS=1, digit i (i>0) is dark if active nibbles i..DIGITS-1
//     are all 0. dp_en still lights the dp of a suppressed digit.
//   Per-cycle output register (1 clk latency after idx changes):
//     AN <= ~(1<<idx);
//     dark = blank[idx] | (blink_en[idx] & blink_off) | lz_dark[idx];
//     SEGMENT[6:0] <= dark ? 7'h7F : hex7(active nibble idx);
//     SEGMENT[7] <= (blank[idx] | (blink_en[idx] & blink_off)) ? 1 : ~dp_en[idx].
//   hex7 (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//     8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//   Exactly one AN bit is low at every cycle after the first post-reset edge.
//   rst mid-scan returns to reset state on that edge. Pending loads and
//     blink phase are lost.
// STRUCTURE
//   Package seg_pkg: HEX7 lookup constant/function, SEG_OFF=8'hFF,
//     segment bit-order localparams.
//   Sub-module seg_hex_decode (combinational nibble->7 seg, from seg_pkg).
//   Top: divider, idx counter, frame/blink counter, shadow+active regs,
//     LZ mask, output regs.
// TESTING (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
//   1 Reset: hold rst 3 cycles -> AN=4'hF, SEGMENT=8'hFF; after release AN=4'hE
//     held for 4 clks, then D,B,7, then E again.
//   2 load disp_num=16'hABCD at frame start -> digits 0..3 show
//     SEGMENT=8'hA1,C6,83,88 (d,C,b,A), dp off.
//   3 load mid-frame (idx=1) 16'h1234 -> current frame keeps old value, next
//     frame shows 0x99,0xB0,0xA4,0xF9.
//   4 blank=4'b0100, dp_en=4'b0001, 16'h0000 -> digit2 SEGMENT=FF,
//     digit0=8'h40, others 8'hC0.
//   5 blink_en=4'h1 -> digit 0 alternates value/FF every 2 frames (32 clks).
//   6 LZ_SUPPRESS=1, 16'h0050 -> digits 3,2 = FF, digit1=8'h92, digit0=8'hC0.
//     Also 16'h0000 -> only digit0 lit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit order,
// the dark pattern and the hex nibble glyph table.
package seg_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned SEG_DP = 7;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_A  = 0;

  localparam logic [SEG_W-1:0] SEG_OFF  = 8'hFF;
  localparam logic [6:0]       SEG7_OFF = 7'h7F;

  // Active-low gfedcba glyphs for 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7_c
);

  always_comb seg7_c = hex7(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous
// shadow loading, per-digit blank/dp/blink and optional leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          LZ_SUPPRESS  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] disp_num,
  input  logic [DIGITS-1:0]   dp_en,
  input  logic [DIGITS-1:0]   blank,
  input  logic [DIGITS-1:0]   blink_en,
  output logic [DIGITS-1:0]   AN,
  output logic [SEG_W-1:0]    SEGMENT
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned NUM_W = 4 * DIGITS;

  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  idx;
  logic [FRM_W-1:0]  frame_cnt;
  logic              blink_off;
  logic              load_pend;

  logic [NUM_W-1:0]  sh_num, act_num;
  logic [DIGITS-1:0] sh_dp, sh_blank, sh_blink;
  logic [DIGITS-1:0] act_dp, act_blank, act_blink;

  logic              tick_c, frame_end_c, blink_wrap_c;
  logic [DIGITS-1:0] lz_dark_c;
  logic [3:0]        nibble_c;
  logic [6:0]        seg7_c;
  logic              dim_c, dark_c;
  logic [DIGITS-1:0] an_nxt_c;
  logic [SEG_W-1:0]  seg_nxt_c;

  assign tick_c       = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end_c  = tick_c && (idx == IDX_W'(DIGITS - 1));
  assign blink_wrap_c = frame_end_c && (frame_cnt == FRM_W'(BLINK_FRAMES - 1));

  // Slot divider, digit index and frame/blink counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (tick_c) begin
        idx <= frame_end_c ? '0 : idx + IDX_W'(1);
      end
      if (frame_end_c) begin
        frame_cnt <= blink_wrap_c ? '0 : frame_cnt + FRM_W'(1);
        if (blink_wrap_c) begin
          blink_off <= ~blink_off;
        end
      end
    end
  end

  // Shadow captures every load; active only changes on a frame boundary,
  // and a load landing on that boundary bypasses the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_pend <= 1'b0;
      sh_num    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_blink  <= '0;
      act_num   <= '0;
      act_dp    <= '0;
      act_blank <= '0;
      act_blink <= '0;
    end else begin
      if (load) begin
        sh_num   <= disp_num;
        sh_dp    <= dp_en;
        sh_blank <= blank;
        sh_blink <= blink_en;
      end
      if (frame_end_c) begin
        load_pend <= 1'b0;
        if (load) begin
          act_num   <= disp_num;
          act_dp    <= dp_en;
          act_blank <= blank;
          act_blink <= blink_en;
        end else if (load_pend) begin
          act_num   <= sh_num;
          act_dp    <= sh_dp;
          act_blank <= sh_blank;
          act_blink <= sh_blink;
        end
      end else if (load) begin
        load_pend <= 1'b1;
      end
    end
  end

  // Digit i>0 is a leading zero when it and every digit above it is zero.
  always_comb begin : lz_mask
    logic zero_above;
    lz_dark_c  = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      zero_above   = zero_above && (act_num[4*i +: 4] == 4'h0);
      lz_dark_c[i] = LZ_SUPPRESS && zero_above;
    end
  end

  always_comb nibble_c = act_num[{idx, 2'b00} +: 4];

  seg_hex_decode u_hex (
    .nibble (nibble_c),
    .seg7_c (seg7_c)
  );

  // Leading-zero blanking darkens the glyph but leaves the dp alone.
  always_comb begin
    an_nxt_c      = '1;
    an_nxt_c[idx] = 1'b0;
    dim_c         = act_blank[idx] | (act_blink[idx] & blink_off);
    dark_c        = dim_c | lz_dark_c[idx];
    seg_nxt_c                = SEG_OFF;
    seg_nxt_c[SEG_G:SEG_A]   = dark_c ? SEG7_OFF : seg7_c;
    seg_nxt_c[SEG_DP]        = dim_c | ~act_dp[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      AN      <= '1;
      SEGMENT <= SEG_OFF;
    end else begin
      AN      <= an_nxt_c;
      SEGMENT <= seg_nxt_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, 4 clk slots, 2-frame blink).
module tb_seg_scan_driver;

  localparam int unsigned DIGITS       = 4;
  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] disp_num;
  logic [3:0]  dp_en, blank, blink_en;
  logic [3:0]  an, an_lz;
  logic [7:0]  seg, seg_lz;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES), .LZ_SUPPRESS(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .disp_num(disp_num), .dp_en(dp_en),
    .blank(blank), .blink_en(blink_en), .AN(an), .SEGMENT(seg)
  );

  seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES), .LZ_SUPPRESS(1'b1)
  ) dut_lz (
    .clk(clk), .rst(rst), .load(load), .disp_num(disp_num), .dp_en(dp_en),
    .blank(blank), .blink_en(blink_en), .AN(an_lz), .SEGMENT(seg_lz)
  );

  function automatic exp_t mk(input logic [3:0] a, input logic [7:0] s);
    exp_t e;
    e.an  = a;
    e.seg = s;
    return e;
  endfunction

  // Called at a negedge; load is sampled on the following posedge.
  task automatic drive_load(input logic [15:0] num, input logic [3:0] dp,
                            input logic [3:0] bl, input logic [3:0] bk);
    disp_num = num;
    dp_en    = dp;
    blank    = bl;
    blink_en = bk;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Waits (bounded) for AN to newly enter the wanted pattern.
  task automatic wait_enter(input bit use_lz, input logic [3:0] want, output bit ok);
    logic [3:0] prev, cur;
    ok   = 1'b0;
    prev = use_lz ? an_lz : an;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cur = use_lz ? an_lz : an;
      if (cur == want && prev != want) begin
        ok = 1'b1;
        break;
      end
      prev = cur;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   slot;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== 4'hF || seg !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: AN=%h SEGMENT=%h want F/FF", i, an, seg);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      slot = ((k - 1) / 4) % 4;
      sb.push_back(mk(~(4'b0001 << slot), 8'hC0));
    end
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (an !== e.an || seg !== e.seg) begin
        n_fail++;
        $display("FAIL reset_scan k=%0d: AN=%h SEGMENT=%h want %h/%h", k, an, seg, e.an, e.seg);
      end
    end
  endtask

  task automatic test_load_frame_start();
    exp_t e;
    bit   ok;
    drive_load(16'hABCD, 4'h0, 4'h0, 4'h0);
    sb.push_back(mk(4'hE, 8'hA1));
    sb.push_back(mk(4'hD, 8'hC6));
    sb.push_back(mk(4'hB, 8'h83));
    sb.push_back(mk(4'h7, 8'h88));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_enter(1'b0, e.an, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL load_abcd: AN never entered %h (now %h)", e.an, an);
      end else if (seg !== e.seg) begin
        n_fail++;
        $display("FAIL load_abcd AN=%h: SEGMENT=%h want %h", e.an, seg, e.seg);
      end
    end
  endtask

  task automatic test_mid_frame_load();
    exp_t e;
    bit   ok;
    wait_enter(1'b0, 4'hE, ok);
    wait_enter(1'b0, 4'hD, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_sync: AN=%h never reached D", an);
    end
    drive_load(16'h1234, 4'h0, 4'h0, 4'h0);
    sb.push_back(mk(4'hB, 8'h83));
    sb.push_back(mk(4'h7, 8'h88));
    sb.push_back(mk(4'hE, 8'h99));
    sb.push_back(mk(4'hD, 8'hB0));
    sb.push_back(mk(4'hB, 8'hA4));
    sb.push_back(mk(4'h7, 8'hF9));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_enter(1'b0, e.an, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL mid_load: AN never entered %h (now %h)", e.an, an);
      end else if (seg !== e.seg) begin
        n_fail++;
        $display("FAIL mid_load AN=%h: SEGMENT=%h want %h", e.an, seg, e.seg);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    wait_enter(1'b0, 4'hD, ok);
    disp_num = 16'h9999;
    load     = 1'b1;
    @(negedge clk);
    disp_num = 16'h5678;
    @(negedge clk);
    load     = 1'b0;
    sb.push_back(mk(4'hE, 8'h80));
    sb.push_back(mk(4'hD, 8'hF8));
    sb.push_back(mk(4'hB, 8'h82));
    sb.push_back(mk(4'h7, 8'h92));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_enter(1'b0, e.an, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL back_to_back: AN never entered %h (now %h)", e.an, an);
      end else if (seg !== e.seg) begin
        n_fail++;
        $display("FAIL back_to_back AN=%h: SEGMENT=%h want %h", e.an, seg, e.seg);
      end
    end
  endtask

  task automatic test_load_at_frame_end();
    exp_t e;
    bit   ok;
    wait_enter(1'b0, 4'h7, ok);
    @(negedge clk);
    @(negedge clk);
    drive_load(16'hE0F7, 4'h0, 4'h0, 4'h0);
    for (int f = 0; f < 2; f++) begin
      sb.push_back(mk(4'hE, 8'hF8));
      sb.push_back(mk(4'hD, 8'h8E));
      sb.push_back(mk(4'hB, 8'hC0));
      sb.push_back(mk(4'h7, 8'h86));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_enter(1'b0, e.an, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL frame_end_load: AN never entered %h (now %h)", e.an, an);
      end else if (seg !== e.seg) begin
        n_fail++;
        $display("FAIL frame_end_load AN=%h: SEGMENT=%h want %h", e.an, seg, e.seg);
      end
    end
  endtask

  task automatic test_blank_dp();
    exp_t e;
    bit   ok;
    drive_load(16'h0000, 4'b0001, 4'b0100, 4'h0);
    sb.push_back(mk(4'hE, 8'h40));
    sb.push_back(mk(4'hD, 8'hC0));
    sb.push_back(mk(4'hB, 8'hFF));
    sb.push_back(mk(4'h7, 8'hC0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_enter(1'b0, e.an, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL blank_dp: AN never entered %h (now %h)", e.an, an);
      end else if (seg !== e.seg) begin
        n_fail++;
        $display("FAIL blank_dp AN=%h: SEGMENT=%h want %h", e.an, seg, e.seg);
      end
    end
  endtask

  // Fresh reset so the blink phase is known: frames 2,3 and 6 are the off frames.
  task automatic test_blink();
    exp_t e;
    bit   ok;
    logic [7:0] d0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_scan_reset: AN=%h SEGMENT=%h want F/FF", an, seg);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_load(16'h8421, 4'h0, 4'h0, 4'h1);
    for (int f = 1; f <= 6; f++) begin
      d0 = (f == 2 || f == 3 || f == 6) ? 8'hFF : 8'hF9;
      sb.push_back(mk(4'hE, d0));
      sb.push_back(mk(4'hD, 8'hA4));
      sb.push_back(mk(4'hB, 8'h99));
      sb.push_back(mk(4'h7, 8'h80));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_enter(1'b0, e.an, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL blink: AN never entered %h (now %h)", e.an, an);
      end else if (seg !== e.seg) begin
        n_fail++;
        $display("FAIL blink AN=%h: SEGMENT=%h want %h", e.an, seg, e.seg);
      end
    end
  endtask

  task automatic test_lz();
    exp_t e;
    bit   ok;
    drive_load(16'h0050, 4'h0, 4'h0, 4'h0);
    sb.push_back(mk(4'hE, 8'hC0));
    sb.push_back(mk(4'hD, 8'h92));
    sb.push_back(mk(4'hB, 8'hFF));
    sb.push_back(mk(4'h7, 8'hFF));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_enter(1'b1, e.an, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL lz_0050: AN never entered %h (now %h)", e.an, an_lz);
      end else if (seg_lz !== e.seg) begin
        n_fail++;
        $display("FAIL lz_0050 AN=%h: SEGMENT=%h want %h", e.an, seg_lz, e.seg);
      end
    end
    drive_load(16'h0000, 4'b0100, 4'h0, 4'h0);
    sb.push_back(mk(4'hE, 8'hC0));
    sb.push_back(mk(4'hD, 8'hFF));
    sb.push_back(mk(4'hB, 8'h7F));
    sb.push_back(mk(4'h7, 8'hFF));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_enter(1'b1, e.an, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL lz_0000: AN never entered %h (now %h)", e.an, an_lz);
      end else if (seg_lz !== e.seg) begin
        n_fail++;
        $display("FAIL lz_0000 AN=%h: SEGMENT=%h want %h", e.an, seg_lz, e.seg);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    disp_num = '0;
    dp_en    = '0;
    blank    = '0;
    blink_en = '0;
    test_reset();
    test_load_frame_start();
    test_mid_frame_load();
    test_back_to_back();
    test_load_at_frame_end();
    test_blank_dp();
    test_blink();
    test_lz();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
